// File: rtl/y86_fetch_decode_execute.sv
// y86_fetch_decode_execute
//    Front half of the sequential Y86-64 datapath. Parses the instruction
//    bytes at pc, picks register-file read addresses, forms the ALU operands,
//    runs the ALU, evaluates the branch/cmov condition and holds the
//    architectural condition codes.
//
// Ports
//    clk, rst          rising-edge clock, synchronous active-high reset
//    pc                address of the current instruction
//    ibytes            instruction bytes pc..pc+9, byte k at [8k+7:8k]
//    rdA, rdB          register-file read data for srcA / srcB
//    srcA, srcB        register read addresses (0xF = none)
//    icode, ifun       opcode fields of byte 0
//    rA, rB            register fields of byte 1 (0xF when not present)
//    valC, valP        constant word, address of the next instruction
//    valA, valB        operands (0 when the matching src is 0xF)
//    valE, cnd         ALU result, condition result
//    zf, sf, of        condition-code register
//    inst_valid        icode/ifun legal
//    imem_er, hlt_er   pc out of instruction memory, halt instruction

module y86_fetch_decode_execute #(
   parameter int unsigned IMEM_SIZE = 2048
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] pc,
   input  logic [79:0] ibytes,
   input  logic [63:0] rdA,
   input  logic [63:0] rdB,
   output logic [3:0]  srcA,
   output logic [3:0]  srcB,
   output logic [3:0]  icode,
   output logic [3:0]  ifun,
   output logic [3:0]  rA,
   output logic [3:0]  rB,
   output logic [63:0] valC,
   output logic [63:0] valP,
   output logic [63:0] valA,
   output logic [63:0] valB,
   output logic [63:0] valE,
   output logic        cnd,
   output logic        zf,
   output logic        sf,
   output logic        of,
   output logic        inst_valid,
   output logic        imem_er,
   output logic        hlt_er
);

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] R_RSP    = 4'h4;
   localparam logic [3:0] R_NONE   = 4'hF;

   localparam logic [1:0] ALU_ADD  = 2'd0;
   localparam logic [1:0] ALU_SUB  = 2'd1;
   localparam logic [1:0] ALU_AND  = 2'd2;
   localparam logic [1:0] ALU_XOR  = 2'd3;

   logic [3:0]  ins_len;
   logic        has_regs;
   logic [63:0] alu_a;
   logic [63:0] alu_b;
   logic [1:0]  alu_fn;
   logic        new_zf;
   logic        new_sf;
   logic        new_of;
   logic        cc_update;

   // fetch: field split, length, constant word, legality
   always_comb begin
      icode    = ibytes[7:4];
      ifun     = ibytes[3:0];
      has_regs = 1'b0;
      ins_len  = 4'd1;
      valC     = 64'd0;
      case (icode)
         I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
            has_regs = 1'b1;
            ins_len  = 4'd2;
         end
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
            has_regs = 1'b1;
            ins_len  = 4'd10;
            valC     = ibytes[79:16];
         end
         I_JXX, I_CALL: begin
            ins_len  = 4'd9;
            valC     = ibytes[71:8];
         end
         default: ins_len = 4'd1;
      endcase
      rA   = has_regs ? ibytes[15:12] : R_NONE;
      rB   = has_regs ? ibytes[11:8]  : R_NONE;
      valP = pc + {60'd0, ins_len};
   end

   always_comb begin
      inst_valid = 1'b0;
      if (icode <= I_POPQ) begin
         case (icode)
            I_RRMOVQ, I_JXX: inst_valid = (ifun <= 4'd6);
            I_OPQ:           inst_valid = (ifun <= 4'd3);
            default:         inst_valid = (ifun == 4'd0);
         endcase
      end
   end

   assign imem_er = (pc >= 64'(IMEM_SIZE));
   assign hlt_er  = (icode == I_HALT);

   // decode
   always_comb begin
      srcA = R_NONE;
      srcB = R_NONE;
      case (icode)
         I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: srcA = rA;
         I_RET, I_POPQ:                      srcA = R_RSP;
         default:                            srcA = R_NONE;
      endcase
      case (icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ:          srcB = rB;
         I_CALL, I_RET, I_PUSHQ, I_POPQ:     srcB = R_RSP;
         default:                            srcB = R_NONE;
      endcase
   end

   assign valA = (srcA == R_NONE) ? 64'd0 : rdA;
   assign valB = (srcB == R_NONE) ? 64'd0 : rdB;

   // execute
   always_comb begin
      alu_a  = 64'd0;
      alu_b  = 64'd0;
      alu_fn = ALU_ADD;
      case (icode)
         I_RRMOVQ, I_OPQ:              alu_a = valA;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = valC;
         I_CALL, I_PUSHQ:              alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
         I_RET, I_POPQ:                alu_a = 64'd8;
         default:                      alu_a = 64'd0;
      endcase
      case (icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = valB;
         default: alu_b = 64'd0;
      endcase
      // ifun values above 3 are illegal for OPq; they fall back to add and
      // never reach the CC register because inst_valid is low
      if (icode == I_OPQ && ifun <= 4'd3) begin
         alu_fn = ifun[1:0];
      end
   end

   always_comb begin
      valE   = 64'd0;
      new_of = 1'b0;
      case (alu_fn)
         ALU_ADD: begin
            valE   = alu_b + alu_a;
            new_of = (alu_a[63] == alu_b[63]) && (valE[63] != alu_a[63]);
         end
         ALU_SUB: begin
            valE   = alu_b - alu_a;
            new_of = (alu_a[63] != alu_b[63]) && (valE[63] != alu_b[63]);
         end
         ALU_AND: valE = alu_a & alu_b;
         ALU_XOR: valE = alu_a ^ alu_b;
         default: valE = 64'd0;
      endcase
      new_zf = (valE == 64'd0);
      new_sf = valE[63];
   end

   // condition uses the CC value held before this instruction's update
   always_comb begin
      cnd = 1'b0;
      if (icode == I_RRMOVQ || icode == I_JXX) begin
         case (ifun)
            4'd0:    cnd = 1'b1;
            4'd1:    cnd = (sf ^ of) | zf;
            4'd2:    cnd = sf ^ of;
            4'd3:    cnd = zf;
            4'd4:    cnd = ~zf;
            4'd5:    cnd = ~(sf ^ of);
            4'd6:    cnd = ~(sf ^ of) & ~zf;
            default: cnd = 1'b0;
         endcase
      end
   end

   assign cc_update = (icode == I_OPQ) && inst_valid && !imem_er;

   always_ff @(posedge clk) begin
      if (rst) begin
         zf <= 1'b0;
         sf <= 1'b0;
         of <= 1'b0;
      end else if (cc_update) begin
         zf <= new_zf;
         sf <= new_sf;
         of <= new_of;
      end
   end

endmodule

// File: tb/tb_y86_fetch_decode_execute.sv
module tb_y86_fetch_decode_execute;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] pc;
   logic [79:0] ibytes;
   logic [63:0] rdA, rdB;
   logic [3:0]  srcA, srcB, icode, ifun, rA, rB;
   logic [63:0] valC, valP, valA, valB, valE;
   logic        cnd, zf, sf, of, inst_valid, imem_er, hlt_er;

   int total = 0;
   int bad   = 0;

   y86_fetch_decode_execute #(.IMEM_SIZE(2048)) dut (
      .clk(clk), .rst(rst), .pc(pc), .ibytes(ibytes), .rdA(rdA), .rdB(rdB),
      .srcA(srcA), .srcB(srcB), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
      .valC(valC), .valP(valP), .valA(valA), .valB(valB), .valE(valE),
      .cnd(cnd), .zf(zf), .sf(sf), .of(of), .inst_valid(inst_valid),
      .imem_er(imem_er), .hlt_er(hlt_er)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic chk_cc(input string tag, input logic z, input logic s, input logic o);
      chk(tag, {61'd0, zf, sf, of}, {61'd0, z, s, o});
   endtask

   task automatic drive(input logic [63:0] p, input logic [79:0] ib,
                        input logic [63:0] a, input logic [63:0] b);
      pc = p; ibytes = ib; rdA = a; rdB = b;
      #1;
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [79:0] ib2(input logic [7:0] b0, input logic [7:0] b1);
      return {64'd0, b1, b0};
   endfunction

   function automatic logic [79:0] ib10(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [63:0] c);
      return {c, b1, b0};
   endfunction

   function automatic logic [79:0] ib9(input logic [7:0] b0, input logic [63:0] c);
      return {8'd0, c, b0};
   endfunction

   initial begin
      // reset, then irmovq $10, %rdx
      rst = 1'b1;
      drive(64'h0, ib10(8'h30, 8'hF2, 64'd10), 64'h0, 64'h0);
      edge_step();
      rst = 1'b0;
      chk_cc("reset_cc", 1'b0, 1'b0, 1'b0);
      chk("irm_icode", icode, 4'h3);
      chk("irm_rA", rA, 4'hF);
      chk("irm_rB", rB, 4'h2);
      chk("irm_valC", valC, 64'd10);
      chk("irm_valP", valP, 64'd10);
      chk("irm_valE", valE, 64'd10);
      chk("irm_srcA", srcA, 4'hF);
      chk("irm_srcB", srcB, 4'hF);
      chk("irm_valid", inst_valid, 1'b1);
      edge_step();
      chk_cc("irm_cc_hold", 1'b0, 1'b0, 1'b0);

      // subq %rdx,%rbx with equal operands
      drive(64'h10, ib2(8'h61, 8'h23), 64'd5, 64'd5);
      chk("sub_srcA", srcA, 4'h2);
      chk("sub_srcB", srcB, 4'h3);
      chk("sub_valE", valE, 64'd0);
      chk("sub_valP", valP, 64'h12);
      edge_step();
      chk_cc("sub_cc", 1'b1, 1'b0, 1'b0);

      // conditional jumps with ZF=1
      drive(64'h20, ib9(8'h73, 64'h100), 64'h0, 64'h0);
      chk("je_cnd", cnd, 1'b1);
      chk("je_valC", valC, 64'h100);
      chk("je_valP", valP, 64'h29);
      chk("je_srcA", srcA, 4'hF);
      drive(64'h20, ib9(8'h74, 64'h100), 64'h0, 64'h0);
      chk("jne_cnd", cnd, 1'b0);
      edge_step();
      chk_cc("jxx_cc_hold", 1'b1, 1'b0, 1'b0);

      // addq overflow
      drive(64'h30, ib2(8'h60, 8'h01), 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
      chk("addov_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
      edge_step();
      chk_cc("addov_cc", 1'b0, 1'b1, 1'b1);

      // conditions with ZF=0 SF=1 OF=1
      drive(64'h40, ib9(8'h71, 64'h0), 64'h0, 64'h0);
      chk("jle_cnd", cnd, 1'b0);
      drive(64'h40, ib9(8'h72, 64'h0), 64'h0, 64'h0);
      chk("jl_cnd", cnd, 1'b0);
      drive(64'h40, ib9(8'h75, 64'h0), 64'h0, 64'h0);
      chk("jge_cnd", cnd, 1'b1);
      drive(64'h40, ib9(8'h76, 64'h0), 64'h0, 64'h0);
      chk("jg_cnd", cnd, 1'b1);
      drive(64'h40, ib2(8'h22, 8'h12), 64'h55, 64'h0);
      chk("cmovl_cnd", cnd, 1'b0);
      chk("cmovl_valE", valE, 64'h55);
      drive(64'h40, ib2(8'h20, 8'h12), 64'h66, 64'h0);
      chk("rrmov_cnd", cnd, 1'b1);
      chk("rrmov_valP", valP, 64'h42);

      // stack operations
      drive(64'h50, ib2(8'hA0, 8'h3F), 64'd7, 64'h200);
      chk("push_srcA", srcA, 4'h3);
      chk("push_srcB", srcB, 4'h4);
      chk("push_valA", valA, 64'd7);
      chk("push_valE", valE, 64'h1F8);
      chk("push_valP", valP, 64'h52);
      drive(64'h60, ib2(8'h90, 8'h00), 64'h1F8, 64'h1F8);
      chk("ret_srcA", srcA, 4'h4);
      chk("ret_srcB", srcB, 4'h4);
      chk("ret_valE", valE, 64'h200);
      chk("ret_valP", valP, 64'h61);
      drive(64'h70, ib9(8'h80, 64'h3A0), 64'h0, 64'h200);
      chk("call_valE", valE, 64'h1F8);
      chk("call_valP", valP, 64'h79);
      chk("call_valC", valC, 64'h3A0);
      chk("call_rA", rA, 4'hF);

      // mrmovq 8(%rdx), %rcx
      drive(64'h80, ib10(8'h50, 8'h12, 64'd8), 64'hDEAD, 64'h100);
      chk("mrm_srcB", srcB, 4'h2);
      chk("mrm_valA", valA, 64'd0);
      chk("mrm_valE", valE, 64'h108);
      chk("mrm_valP", valP, 64'h8A);

      // instruction memory boundary
      drive(64'd2047, ib2(8'h10, 8'h00), 64'h0, 64'h0);
      chk("pc2047_imem", imem_er, 1'b0);
      drive(64'd2048, ib2(8'h61, 8'h11), 64'd1, 64'd1);
      chk("pc2048_imem", imem_er, 1'b1);
      chk("pc2048_valE", valE, 64'd0);
      edge_step();
      chk_cc("imem_cc_hold", 1'b0, 1'b1, 1'b1);

      // illegal encodings
      drive(64'h90, ib2(8'hC0, 8'h00), 64'h0, 64'h0);
      chk("c0_valid", inst_valid, 1'b0);
      chk("c0_valP", valP, 64'h91);
      drive(64'h90, ib2(8'h27, 8'h12), 64'h0, 64'h0);
      chk("cmov7_valid", inst_valid, 1'b0);
      drive(64'h90, ib2(8'h11, 8'h00), 64'h0, 64'h0);
      chk("nop1_valid", inst_valid, 1'b0);
      drive(64'h90, ib2(8'h65, 8'h12), 64'h0, 64'h0);
      chk("op5_valid", inst_valid, 1'b0);
      edge_step();
      chk_cc("op5_cc_hold", 1'b0, 1'b1, 1'b1);

      // halt
      drive(64'hA0, ib2(8'h00, 8'h00), 64'h0, 64'h0);
      chk("halt_er", hlt_er, 1'b1);
      chk("halt_valP", valP, 64'hA1);
      chk("halt_valid", inst_valid, 1'b1);

      // andq / xorq
      drive(64'hB0, ib2(8'h62, 8'h12), 64'hF0, 64'hFF);
      chk("and_valE", valE, 64'hF0);
      drive(64'hB0, ib2(8'h63, 8'h12), 64'hF0, 64'hFF);
      chk("xor_valE", valE, 64'h0F);
      chk("xor_hlt", hlt_er, 1'b0);
      edge_step();
      chk_cc("xor_cc", 1'b0, 1'b0, 1'b0);

      // subq overflow: 0x8000.. - 1
      drive(64'hC0, ib2(8'h61, 8'h12), 64'd1, 64'h8000_0000_0000_0000);
      chk("subov_valE", valE, 64'h7FFF_FFFF_FFFF_FFFF);
      edge_step();
      chk_cc("subov_cc", 1'b0, 1'b0, 1'b1);
      drive(64'hD0, ib9(8'h72, 64'h0), 64'h0, 64'h0);
      chk("jl2_cnd", cnd, 1'b1);
      drive(64'hD0, ib9(8'h75, 64'h0), 64'h0, 64'h0);
      chk("jge2_cnd", cnd, 1'b0);

      // valP wraps at 2^64
      drive(64'hFFFF_FFFF_FFFF_FFFF, ib2(8'h10, 8'h00), 64'h0, 64'h0);
      chk("wrap_valP", valP, 64'h0);
      chk("wrap_imem", imem_er, 1'b1);

      // reset priority over a pending CC update
      drive(64'hE0, ib2(8'h61, 8'h11), 64'd3, 64'd3);
      rst = 1'b1;
      edge_step();
      rst = 1'b0;
      chk_cc("rst_prio_cc", 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/y86_fetch_decode_execute.md
Name: y86_fetch_decode_execute

Overview:
- Front half of the sequential Y86-64 datapath: fetch, decode and execute merged into one block.
- Parses the instruction bytes at the current PC, selects register-file read addresses and sequences operands, runs the ALU, and evaluates the branch/move condition.
- Holds the architectural condition codes (ZF/SF/OF).
- Sits between the PC register / instruction memory and the memory, write_back and pc_update stages.

Parameters:
IMEM_SIZE, 2048, instruction-memory size in bytes; a PC at or above this sets imem_er

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
pc  input  64  address of the current instruction
ibytes  input  80  instruction bytes pc..pc+9; byte k at [8k+7:8k]
rdA  input  64  register-file data for srcA
rdB  input  64  register-file data for srcB
srcA  output  4  register read address A; 0xF = none
srcB  output  4  register read address B; 0xF = none
icode  output  4  byte0[7:4]
ifun  output  4  byte0[3:0]
rA  output  4  byte1[7:4] for register-byte instructions, else 0xF
rB  output  4  byte1[3:0] for register-byte instructions, else 0xF
valC  output  64  constant word
valP  output  64  pc + instruction length
valA  output  64  operand A (rdA, or 0 when srcA = 0xF)
valB  output  64  operand B (rdB, or 0 when srcB = 0xF)
valE  output  64  ALU result
cnd  output  1  condition result
zf, sf, of  output  1 each  current condition-code register
inst_valid  output  1  icode/ifun legal
imem_er  output  1  pc >= IMEM_SIZE
hlt_er  output  1  icode = 0 (halt)

Behaviour:
- All outputs except zf/sf/of are combinational from pc, ibytes, rdA, rdB and the CC register.
- Condition codes are the only state.
  - rst at a rising edge clears ZF/SF/OF to 0; rst has priority over an update in the same cycle.
  - Update at a rising edge only when icode = 6 (OPq), inst_valid = 1, imem_er = 0 and rst = 0.
- Instruction length by icode:
  - 0 halt, 1 nop, 9 ret: 1 byte.
  - 2 rrmovq/cmovXX, 6 OPq, A pushq, B popq: 2 bytes.
  - 3 irmovq, 4 rmmovq, 5 mrmovq: 10 bytes.
  - 7 jXX, 8 call: 9 bytes.
  - Illegal icode: 1 byte.
- valC, little-endian:
  - icode 3/4/5: bytes 2..9.
  - icode 7/8: bytes 1..8.
  - Otherwise 0.
- valP = pc + length, modulo 2^64.
- inst_valid = 1 only when:
  - icode <= 0xB, and
  - for icode 2 or 7: ifun <= 6;
  - for icode 6: ifun <= 3;
  - for all other legal icodes: ifun = 0.
- Decode, with rsp = 4:
  - srcA = rA for icode 2/4/6/A; rsp for icode 9/B; else 0xF.
  - srcB = rB for icode 4/5/6; rsp for icode 8/9/A/B; else 0xF.
- ALU operand A (aluA):
  - valA for icode 2/6.
  - valC for icode 3/4/5.
  - -8 for icode 8/A.
  - +8 for icode 9/B.
  - 0 otherwise.
- ALU operand B (aluB): valB for icode 4/5/6/8/9/A/B; 0 otherwise.
- ALU function:
  - icode 6: ifun 0 = B+A, 1 = B-A, 2 = A&B, 3 = A^B.
  - All other icodes: add.
  - Results wrap at 64 bits.
- Flags computed from the result (latched only under the update rule above):
  - ZF = (valE == 0).
  - SF = valE[63].
  - OF for add: sign(A) == sign(B) and sign(valE) != sign(A).
  - OF for sub: sign(A) != sign(B) and sign(valE) != sign(B).
  - OF for and/xor: 0.
- cnd, evaluated for icode 2 and 7 from the current (pre-update) CC register:
  - ifun 0: 1.
  - 1 le: (SF^OF)|ZF.
  - 2 l: SF^OF.
  - 3 e: ZF.
  - 4 ne: !ZF.
  - 5 ge: !(SF^OF).
  - 6 g: !(SF^OF)&!ZF.
  - cnd = 0 for all other icodes.
- Invalid instruction, halt, or imem_er:
  - All fields are still decoded and driven.
  - CC is not updated.
  - The status flags are left for downstream stages to act on.

Test Plan:
- Reset then irmovq: rst=1 for one edge, then ibytes = 30 F2 0A 00.. with pc=0 -> ZF/SF/OF=0; icode=3, rB=2, valC=10, valP=10, valE=10, srcB=0xF; CC unchanged after the edge.
- OPq sub to zero: 61 23 with rdA=rdB=5 -> valE=0 combinationally; after the edge ZF=1, SF=0, OF=0.
- Overflow add: 60 01 with rdA=rdB=0x7FFF_FFFF_FFFF_FFFF -> valE=0xFFFF_FFFF_FFFF_FFFE; after the edge SF=1, OF=1, ZF=0.
- Conditional jump: with ZF=1 held, 73 + 8-byte dest 0x100 at pc=0x20 -> cnd=1, valC=0x100, valP=0x29; with 74 -> cnd=0.
- Stack ops:
  - pushq 0xA0 0x3F with rdA=7, rdB=0x200 -> srcA=3, srcB=4, valE=0x1F8.
  - ret 0x90 with rdB=0x1F8 -> valE=0x200, valP=pc+1.
- Errors:
  - pc=2048 -> imem_er=1.
  - byte C0 -> inst_valid=0.
  - byte 65 -> inst_valid=0, no CC update.
  - byte 00 -> hlt_er=1, valP=pc+1.
